// File: rtl/bru_pkg.sv
// Shared branch-unit definitions: op encodings, skid-buffer states and resolved-beat flag width.
// Included by the decoder and IFU as well as the resolve stage.
package bru_pkg;

  typedef enum logic [2:0] {
    BRU_NONE = 3'd0,
    BRU_BR   = 3'd1,
    BRU_JAL  = 3'd2,
    BRU_JALR = 3'd3
  } bru_op_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_t;

  // Resolved-beat flags carried alongside pc/target/link: taken, redirect, misalign.
  localparam int unsigned BRU_FLAG_W = 3;

endpackage

// File: rtl/bru_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; ready depends only on registered state.
// kill empties the buffer and discards a concurrent push.
module bru_skid_buf
  import bru_pkg::*;
#(
  parameter int unsigned  W         = 8,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         kill,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         push_ready,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  skid_state_t  state, state_next;
  logic [W-1:0] head, spare;
  logic         acc, deq;

  assign push_ready = (state != SKID_TWO);
  assign pop_valid  = (state != SKID_EMPTY);
  assign pop_data   = head;
  assign acc        = push & push_ready & ~kill;
  assign deq        = pop_valid & pop_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SKID_EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (kill) begin
      state_next = SKID_EMPTY;
    end else begin
      unique case (state)
        SKID_EMPTY: if (acc) state_next = SKID_ONE;
        SKID_ONE: begin
          if (acc && !deq)      state_next = SKID_TWO;
          else if (!acc && deq) state_next = SKID_EMPTY;
        end
        SKID_TWO:   if (deq) state_next = SKID_ONE;
        default:    state_next = SKID_EMPTY;
      endcase
    end
  end

  // head is the presented beat; spare only fills while head is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= RESET_VAL;
      spare <= RESET_VAL;
    end else begin
      if (acc && ((state == SKID_EMPTY) || ((state == SKID_ONE) && deq)))
        head <= push_data;
      else if ((state == SKID_TWO) && deq && !kill)
        head <= spare;
      if (acc && (state == SKID_ONE) && !deq)
        spare <= push_data;
    end
  end

endmodule

// File: rtl/bru_resolve.sv
// Branch-resolution stage: resolves direction/target, flags mispredicts, squashes by epoch.
// Define BRU_PERF_EN to add perf_br_cnt / perf_mispred_cnt counters.
module bru_resolve
  import bru_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [2:0]      in_op,
  input  logic            in_cmp,
  input  logic            in_pred_taken,
  input  logic [XLEN-1:0] in_pred_target,
  input  logic            in_epoch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_link,
  output logic            out_redirect,
  output logic            out_misalign,
  output logic            cur_epoch
`ifdef BRU_PERF_EN
  ,
  output logic [31:0]     perf_br_cnt,
  output logic [31:0]     perf_mispred_cnt
`endif
);

`ifdef BRU_PERF_EN
  localparam int unsigned FW = BRU_FLAG_W + 1;
`else
  localparam int unsigned FW = BRU_FLAG_W;
`endif
  localparam int unsigned BW = 3 * XLEN + FW;
  localparam logic [BW-1:0] RST_BEAT = {RESET_PC, RESET_PC, RESET_PC + XLEN'(4), {FW{1'b0}}};

  logic [XLEN-1:0] jalr_sum, tgt, seq_pc, target;
  logic            taken, redirect, misalign;
  logic            push, kill, deq;
  logic [BW-1:0]   in_beat, out_beat;

  always_comb begin
    taken = 1'b0;
    case (in_op)
      BRU_BR:            taken = in_cmp;
      BRU_JAL, BRU_JALR: taken = 1'b1;
      default:           taken = 1'b0;
    endcase
  end

  assign jalr_sum = in_rs1 + in_imm;
  assign tgt      = (in_op == BRU_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : (in_pc + in_imm);
  assign seq_pc   = in_pc + XLEN'(4);
  assign target   = taken ? tgt : seq_pc;
  assign misalign = taken & (|tgt[1:0]);
  // A misaligned target traps instead of restarting fetch, so it never redirects.
  assign redirect = ((taken != in_pred_taken) |
                     (taken & in_pred_taken & (tgt != in_pred_target))) & ~misalign;

`ifdef BRU_PERF_EN
  logic out_is_br;
  assign in_beat = {in_pc, target, seq_pc, taken, redirect, misalign, (in_op != BRU_NONE)};
  assign {out_pc, out_target, out_link, out_taken, out_redirect, out_misalign, out_is_br} = out_beat;
`else
  assign in_beat = {in_pc, target, seq_pc, taken, redirect, misalign};
  assign {out_pc, out_target, out_link, out_taken, out_redirect, out_misalign} = out_beat;
`endif

  // Wrong-epoch beats still handshake (in_ready unaffected) but never enter the buffer.
  assign push = in_valid & (in_epoch == cur_epoch);
  assign deq  = out_valid & out_ready;
  assign kill = flush_i | (deq & out_redirect);

  bru_skid_buf #(
    .W         (BW),
    .RESET_VAL (RST_BEAT)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .kill       (kill),
    .push       (push),
    .push_data  (in_beat),
    .push_ready (in_ready),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (out_beat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cur_epoch <= 1'b0;
    else if (kill) cur_epoch <= ~cur_epoch;
  end

`ifdef BRU_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_br_cnt      <= '0;
      perf_mispred_cnt <= '0;
    end else if (deq && !flush_i) begin
      if (out_is_br)    perf_br_cnt      <= perf_br_cnt + 32'd1;
      if (out_redirect) perf_mispred_cnt <= perf_mispred_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bru_resolve.sv
// Self-checking bench for bru_resolve: queue-based reference model, directed cases, random traffic.
module tb_bru_resolve;
  import bru_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0, in_imm = '0, in_rs1 = '0, in_pred_target = '0;
  logic [2:0]  in_op = '0;
  logic        in_cmp = 1'b0, in_pred_taken = 1'b0, in_epoch = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_pc, out_target, out_link;
  logic        out_taken, out_redirect, out_misalign, cur_epoch;

  always #5 clk = ~clk;

  bru_resolve #(
    .XLEN     (32),
    .RESET_PC (32'h8000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush_i),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_imm         (in_imm),
    .in_rs1         (in_rs1),
    .in_op          (in_op),
    .in_cmp         (in_cmp),
    .in_pred_taken  (in_pred_taken),
    .in_pred_target (in_pred_target),
    .in_epoch       (in_epoch),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_taken      (out_taken),
    .out_target     (out_target),
    .out_link       (out_link),
    .out_redirect   (out_redirect),
    .out_misalign   (out_misalign),
    .cur_epoch      (cur_epoch)
  );

  typedef struct {
    logic [31:0] pc, target, link;
    logic        taken, redirect, misalign;
  } beat_t;

  beat_t       q[$];
  logic        m_epoch = 1'b0;
  int unsigned total = 0, bad = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t resolve_ref();
    beat_t       b;
    logic [31:0] dest;
    logic        jump;
    case (in_op)
      3'd1:       jump = in_cmp;
      3'd2, 3'd3: jump = 1'b1;
      default:    jump = 1'b0;
    endcase
    dest       = (in_op == 3'd3) ? ((in_rs1 + in_imm) & 32'hFFFF_FFFE) : (in_pc + in_imm);
    b.pc       = in_pc;
    b.link     = in_pc + 32'd4;
    b.taken    = jump;
    b.target   = jump ? dest : in_pc + 32'd4;
    b.misalign = jump && (dest % 4 != 0);
    b.redirect = !b.misalign && ((jump != in_pred_taken) || (jump && dest != in_pred_target));
    return b;
  endfunction

  // Advances the model by one clock edge using the inputs presented at that edge.
  task automatic model_step();
    bit acc, deq, kill;
    acc = in_valid && (q.size() < 2);
    deq = (q.size() > 0) && out_ready;
    if (flush_i) begin
      q.delete();
      m_epoch = ~m_epoch;
    end else begin
      kill = deq && q[0].redirect;
      if (deq) void'(q.pop_front());
      if (kill) begin
        q.delete();
        m_epoch = ~m_epoch;
      end else if (acc && (in_epoch == m_epoch)) begin
        q.push_back(resolve_ref());
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 32'(in_ready), 32'(q.size() < 2));
      check("out_valid", 32'(out_valid), 32'(q.size() > 0));
      check("cur_epoch", 32'(cur_epoch), 32'(m_epoch));
      if (q.size() > 0) begin
        check("out_pc", out_pc, q[0].pc);
        check("out_target", out_target, q[0].target);
        check("out_link", out_link, q[0].link);
        check("out_flags", {29'd0, out_taken, out_redirect, out_misalign},
              {29'd0, q[0].taken, q[0].redirect, q[0].misalign});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_beat(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] rs1, input logic cmp, input logic pt,
                          input logic [31:0] ptgt, input logic ep);
    in_valid = 1'b1; in_op = op; in_pc = pc; in_imm = imm; in_rs1 = rs1;
    in_cmp = cmp; in_pred_taken = pt; in_pred_target = ptgt; in_epoch = ep;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_pc", out_pc, 32'h8000_0000);
    check("rst_out_target", out_target, 32'h8000_0000);
    check("rst_out_link", out_link, 32'h8000_0004);
    check("rst_flags", {29'd0, out_taken, out_redirect, out_misalign}, 32'd0);
    check("rst_epoch", 32'(cur_epoch), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // BR taken, predicted not-taken: redirect, epoch flips on dequeue.
    set_beat(BRU_BR, 32'h8000_0010, 32'h20, '0, 1'b1, 1'b0, '0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("br_taken", 32'(out_taken), 32'd1);
    check("br_target", out_target, 32'h8000_0030);
    check("br_redirect", 32'(out_redirect), 32'd1);
    out_ready = 1'b1;
    tick();
    check("br_epoch", 32'(cur_epoch), 32'd1);

    // JALR clears bit 0 of the target; bit 1 set makes it misaligned.
    set_beat(BRU_JALR, 32'h8000_0100, 32'h0, 32'h8000_1003, 1'b0, 1'b1, 32'h8000_1002, 1'b1);
    tick();
    in_valid = 1'b0;
    check("jalr_target", out_target, 32'h8000_1002);
    check("jalr_redirect", 32'(out_redirect), 32'd0);
    check("jalr_link", out_link, 32'h8000_0104);
    check("jalr_misalign", 32'(out_misalign), 32'd1);
    tick();

    // Backpressure: three offered beats, two held, order preserved.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_beat(BRU_NONE, 32'h8000_0200 + 32'(i * 4), '0, '0, 1'b0, 1'b0, '0, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_hold_pc", out_pc, 32'h8000_0200);
    out_ready = 1'b1;
    tick();
    check("bp_second_pc", out_pc, 32'h8000_0204);
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Redirect at head squashes the younger buffered beat and later stale-epoch beats.
    out_ready = 1'b0;
    set_beat(BRU_BR, 32'h8000_0300, 32'h40, '0, 1'b1, 1'b0, '0, 1'b1);
    tick();
    set_beat(BRU_NONE, 32'h8000_0304, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("sq_empty", 32'(out_valid), 32'd0);
    check("sq_epoch", 32'(cur_epoch), 32'd0);
    set_beat(BRU_NONE, 32'h8000_0308, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    tick();
    in_valid = 1'b0;
    check("sq_stale_drop", 32'(out_valid), 32'd0);

    // Flush while full with a concurrent offered beat.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_beat(BRU_NONE, 32'h8000_0400 + 32'(i * 4), '0, '0, 1'b0, 1'b0, '0, 1'b0);
      tick();
    end
    set_beat(BRU_NONE, 32'h8000_0408, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    in_valid = 1'b0;
    check("fl_empty", 32'(out_valid), 32'd0);
    check("fl_ready", 32'(in_ready), 32'd1);
    check("fl_epoch", 32'(cur_epoch), 32'd1);

    // JAL target wraps mod 2^32; a misaligned target suppresses redirect.
    out_ready = 1'b1;
    set_beat(BRU_JAL, 32'hFFFF_FFF0, 32'h20, '0, 1'b0, 1'b1, 32'h0000_0010, 1'b1);
    tick();
    check("jal_wrap_target", out_target, 32'h0000_0010);
    check("jal_wrap_redirect", 32'(out_redirect), 32'd0);
    set_beat(BRU_JAL, 32'hFFFF_FFF0, 32'h22, '0, 1'b0, 1'b0, '0, 1'b1);
    tick();
    in_valid = 1'b0;
    check("jal_mis_target", out_target, 32'h0000_0012);
    check("jal_mis_flags", {29'd0, out_taken, out_redirect, out_misalign}, 32'd5);
    tick();

    for (int n = 0; n < 3000; n++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_op    = 3'($urandom_range(0, 3));
      in_pc    = $urandom & 32'hFFFF_FFFC;
      in_imm   = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      in_rs1   = $urandom;
      in_cmp   = 1'($urandom_range(0, 1));
      in_pred_taken  = 1'($urandom_range(0, 1));
      in_pred_target = ($urandom_range(0, 1) == 1) ? resolve_ref().target : $urandom;
      in_epoch = ($urandom_range(0, 9) < 8) ? m_epoch : ~m_epoch;
      out_ready = ($urandom_range(0, 9) < 6);
      flush_i   = ($urandom_range(0, 49) == 0);
      if (n == 1500) begin
        in_valid = 1'b1;
        in_epoch = m_epoch;
        flush_i  = 1'b0;
        @(posedge clk);
        model_step();
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        q.delete();
        m_epoch = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_epoch", 32'(cur_epoch), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        rst_n  = 1'b1;
        chk_en = 1'b1;
      end else begin
        tick();
      end
    end

    in_valid = 1'b0;
    flush_i  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
